// File: rtl/seq_test_ctrl.sv
// -----------------------------------------------------------------------------
// seq_test_ctrl
//   Stimulus/score controller for the serial sequence detector. A start request
//   accepted in IDLE latches a bit pattern and length, then shifts the pattern
//   out MSB-first on data_out, one bit per DIV cycles. A drain period of 2*DIV
//   cycles follows so late detector responses are still scored. Rising edges of
//   detected_in seen while shifting or draining are counted (saturating) and the
//   count is reported with a busy/done handshake.
//
// Ports
//   sysclk      : system clock, all logic on the rising edge
//   rst         : asynchronous active-high reset
//   start       : run request, only honoured in IDLE
//   pattern     : bits to send; bit pat_len-1 goes out first, bit 0 last
//   pat_len     : number of bits to send, clamped to PAT_W
//   detected_in : detector output level
//   data_out    : serial bit to the detector
//   bit_strobe  : one-cycle pulse on the first cycle of each bit
//   busy        : high while shifting or draining
//   done        : one-cycle pulse when a run completes
//   match_cnt   : detected_in rising edges seen during the last run
// -----------------------------------------------------------------------------
module seq_test_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             detected_in,
  output logic             data_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  // The divider is reused by DRAIN, so it must reach 2*DIV-1.
  localparam int DIV_W = $clog2(2 * DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DRAIN_LAST = DIV_W'(2 * DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [PAT_W-1:0] pat_r;
  logic [IDX_W-1:0] idx_r;
  logic [DIV_W-1:0] div_r;
  logic             det_q;

  logic [1:0]       state_s;
  logic [PAT_W-1:0] pat_s;
  logic [IDX_W-1:0] idx_s;
  logic [DIV_W-1:0] div_s;
  logic [LEN_W-1:0] len_clamp_s;
  logic             start_acc_s;
  logic             rise_s;
  logic             scoring_s;
  logic             data_s;
  logic             strobe_s;
  logic             busy_s;
  logic             done_s;
  logic [CNT_W-1:0] cnt_s;

  // Next-state logic for the run sequencer: pattern latch, bit index and divider.
  always_comb begin
    state_s     = state_r;
    pat_s       = pat_r;
    idx_s       = idx_r;
    div_s       = div_r;
    start_acc_s = 1'b0;
    if (pat_len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = pat_len;
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          pat_s       = pattern;
          div_s       = {DIV_W{1'b0}};
          // Underflow for a zero length is harmless: SHIFT is skipped.
          idx_s       = IDX_W'(len_clamp_s - LEN_W'(1));
          if (len_clamp_s == {LEN_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = {DIV_W{1'b0}};
          if (idx_r == {IDX_W{1'b0}}) begin
            state_s = ST_DRAIN;
          end else begin
            idx_s = idx_r - IDX_W'(1);
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_DRAIN: begin
        if (div_r == DRAIN_LAST) begin
          div_s   = {DIV_W{1'b0}};
          state_s = ST_DONE;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output and score next values; outputs are decoded from the next state so
  // the registered versions line up with the state they describe.
  always_comb begin
    rise_s    = detected_in & ~det_q;
    scoring_s = (state_r == ST_SHIFT) || (state_r == ST_DRAIN);
    if (state_s == ST_SHIFT) begin
      data_s   = pat_s[idx_s];
      strobe_s = (div_s == {DIV_W{1'b0}});
    end else begin
      data_s   = 1'b0;
      strobe_s = 1'b0;
    end
    busy_s = (state_s == ST_SHIFT) || (state_s == ST_DRAIN);
    done_s = (state_s == ST_DONE);
    // Clearing on an accepted start takes priority over any coincident rise.
    if (start_acc_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (scoring_s && rise_s && (match_cnt != CNT_MAX)) begin
      cnt_s = match_cnt + CNT_W'(1);
    end else begin
      cnt_s = match_cnt;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pat_r      <= {PAT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      det_q      <= 1'b0;
      data_out   <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match_cnt  <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      pat_r      <= pat_s;
      idx_r      <= idx_s;
      div_r      <= div_s;
      det_q      <= detected_in;
      data_out   <= data_s;
      bit_strobe <= strobe_s;
      busy       <= busy_s;
      done       <= done_s;
      match_cnt  <= cnt_s;
    end
  end

endmodule

// File: tb/tb_seq_test_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_test_ctrl
//   Scoreboard bench for seq_test_ctrl. The driver issues runs (directed and
//   random) and, at the moment a start is issued, pushes the expected run
//   (start cycle, clamped length, pattern, done cycle, expected counts) into a
//   queue. A monitor samples on the falling edge and compares every cycle's
//   outputs against the run at the head of the queue, checking the counts when
//   done appears. A second instance with CNT_W=2 checks saturation.
// -----------------------------------------------------------------------------
module tb_seq_test_ctrl;

  localparam int DIV = 4;

  typedef struct {
    int          k;
    int          len;
    logic [15:0] pat;
    int          d;
    int          c8;
    int          c2;
  } run_t;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = 16'h0000;
  logic [4:0]  pat_len = 5'd0;
  logic        detected_in = 1'b0;

  logic        data_out, bit_strobe, busy, done;
  logic [7:0]  match_cnt;
  logic        s_data_out, s_bit_strobe, s_busy, s_done;
  logic [1:0]  s_match_cnt;

  seq_test_ctrl #(.PAT_W(16), .LEN_W(5), .DIV(DIV), .CNT_W(8)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .pattern(pattern),
    .pat_len(pat_len), .detected_in(detected_in), .data_out(data_out),
    .bit_strobe(bit_strobe), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  seq_test_ctrl #(.PAT_W(16), .LEN_W(5), .DIV(DIV), .CNT_W(2)) dut_sat (
    .sysclk(sysclk), .rst(rst), .start(start), .pattern(pattern),
    .pat_len(pat_len), .detected_in(detected_in), .data_out(s_data_out),
    .bit_strobe(s_bit_strobe), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt)
  );

  always #5 sysclk = ~sysclk;

  // Edge counter: during the period after edge e we are in cycle e+1.
  int edge_n = 0;
  always @(posedge sysclk) edge_n <= edge_n + 1;

  run_t exp_q[$];
  int   last_done = -1;
  logic plan [0:127];

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- driver
  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int cur_cycle();
    return edge_n + 1;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 128; i++) plan[i] = 1'b0;
  endtask

  task automatic set_plan(input int a, input int b);
    for (int i = a; i <= b; i++) plan[i] = 1'b1;
  endtask

  task automatic random_plan();
    for (int i = 0; i < 128; i++) plan[i] = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) next_cycle();
  endtask

  // Issue one run; abort_at>0 asserts rst that many cycles after the start.
  task automatic do_run(input logic [15:0] p, input logic [4:0] l,
                        input bit hold, input int abort_at);
    run_t r;
    int   span;
    int   n;
    next_cycle();
    while (cur_cycle() <= last_done) begin
      start = hold;
      next_cycle();
    end
    start       = 1'b1;
    pattern     = p;
    pat_len     = l;
    detected_in = plan[0];
    r.k   = cur_cycle();
    r.len = (int'(l) > 16) ? 16 : int'(l);
    r.pat = p;
    span  = (r.len == 0) ? 0 : (r.len + 2) * DIV;
    r.d   = r.k + span + 1;
    n = 0;
    for (int o = 1; o <= span; o++) begin
      if (plan[o] && !plan[o-1]) n++;
    end
    r.c8 = (n > 255) ? 255 : n;
    r.c2 = (n > 3) ? 3 : n;
    exp_q.push_back(r);
    last_done = r.d;
    for (int o = 1; o <= r.d - r.k; o++) begin
      next_cycle();
      if (abort_at > 0 && o == abort_at) begin
        rst         = 1'b1;
        start       = 1'b0;
        detected_in = 1'b0;
        last_done   = -1;
        repeat (2) next_cycle();
        rst = 1'b0;
        return;
      end
      detected_in = plan[o];
      if (!hold) begin
        start   = 1'b0;
        pattern = 16'($urandom);
        pat_len = 5'($urandom);
      end
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int   rd = 0;
  int   mon_c;
  int   mon_o;
  bit   mon_have;
  run_t mon_r;
  logic [3:0] exp_v;
  logic [3:0] act_v;
  logic [3:0] act_s;
  logic [7:0] last_c8 = 8'd0;
  logic [1:0] last_c2 = 2'd0;

  always @(negedge sysclk) begin
    mon_c = edge_n + 1;
    if (rst) begin
      rd      = exp_q.size();
      last_c8 = 8'd0;
      last_c2 = 2'd0;
      checks++;
      if ({data_out, bit_strobe, busy, done, match_cnt,
           s_data_out, s_bit_strobe, s_busy, s_done, s_match_cnt} !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got out=%b%b%b%b cnt=%0d, expected all 0",
                 mon_c, data_out, bit_strobe, busy, done, match_cnt);
      end
    end else begin
      exp_v    = 4'b0000;
      mon_have = (rd < exp_q.size());
      if (mon_have) begin
        mon_r    = exp_q[rd];
        mon_have = (mon_c > mon_r.k);
      end
      if (mon_have) begin
        mon_o = mon_c - mon_r.k;
        if (mon_r.len > 0 && mon_o <= mon_r.len * DIV) begin
          exp_v[3] = mon_r.pat[mon_r.len - 1 - (mon_o - 1) / DIV];
          exp_v[2] = ((mon_o - 1) % DIV == 0);
        end
        exp_v[1] = (mon_r.len > 0) && (mon_o <= (mon_r.len + 2) * DIV);
        exp_v[0] = (mon_c == mon_r.d);
      end
      act_v = {data_out, bit_strobe, busy, done};
      act_s = {s_data_out, s_bit_strobe, s_busy, s_done};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got data/strobe/busy/done=%b, expected %b",
                 mon_c, act_v, exp_v);
      end
      checks++;
      if (act_s !== exp_v) begin
        errors++;
        $display("FAIL sat_outputs cycle %0d: got data/strobe/busy/done=%b, expected %b",
                 mon_c, act_s, exp_v);
      end
      if (!mon_have) begin
        checks++;
        if (match_cnt !== last_c8 || s_match_cnt !== last_c2) begin
          errors++;
          $display("FAIL cnt_hold cycle %0d: got %0d/%0d, expected %0d/%0d",
                   mon_c, match_cnt, s_match_cnt, last_c8, last_c2);
        end
      end else if (mon_c == mon_r.d) begin
        checks++;
        if (match_cnt !== 8'(mon_r.c8)) begin
          errors++;
          $display("FAIL match_cnt cycle %0d: got %0d, expected %0d",
                   mon_c, match_cnt, mon_r.c8);
        end
        checks++;
        if (s_match_cnt !== 2'(mon_r.c2)) begin
          errors++;
          $display("FAIL match_cnt_sat cycle %0d: got %0d, expected %0d",
                   mon_c, s_match_cnt, mon_r.c2);
        end
        last_c8 = 8'(mon_r.c8);
        last_c2 = 2'(mon_r.c2);
        rd++;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    idle_cycles(2);

    // Serialization of 16'h001B / 5 bits with a single 4-cycle detect pulse.
    clear_plan(); set_plan(21, 24);
    do_run(16'h001B, 5'd5, 1'b0, 0);
    idle_cycles(1);
    // Two separate pulses.
    clear_plan(); set_plan(10, 12); set_plan(20, 22);
    do_run(16'h001B, 5'd5, 1'b0, 0);
    // One long 12-cycle high.
    clear_plan(); set_plan(14, 25);
    do_run(16'h001B, 5'd5, 1'b0, 0);
    idle_cycles(2);
    // Zero length: done right away, rise during DONE not counted.
    clear_plan(); set_plan(1, 2);
    do_run(16'hFFFF, 5'd0, 1'b0, 0);
    idle_cycles(2);
    // Length 31 clamps to 16 bits.
    clear_plan(); set_plan(30, 31); set_plan(70, 72);
    do_run(16'hA5C3, 5'd31, 1'b0, 0);
    idle_cycles(1);
    // Five rises: 8-bit count 5, 2-bit count saturates at 3.
    clear_plan();
    for (int i = 0; i < 5; i++) set_plan(3 + 5 * i, 4 + 5 * i);
    do_run(16'h3C5A, 5'd6, 1'b0, 0);
    // Start held high across back-to-back runs.
    clear_plan(); set_plan(5, 6);
    do_run(16'h0123, 5'd3, 1'b1, 0);
    do_run(16'h8001, 5'd4, 1'b1, 0);
    idle_cycles(3);
    // Reset mid-SHIFT, then a normal run.
    clear_plan(); set_plan(2, 3);
    do_run(16'h00FF, 5'd8, 1'b0, 6);
    idle_cycles(2);
    clear_plan(); set_plan(8, 9);
    do_run(16'h00B7, 5'd8, 1'b0, 0);

    // Randomized runs.
    for (int it = 0; it < 40; it++) begin
      bit hold;
      random_plan();
      hold = ($urandom_range(0, 3) == 0);
      do_run(16'($urandom), 5'($urandom_range(0, 31)), hold, 0);
      if (!hold) idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
